// File: rtl/dom_rnd_supply.sv
// dom_rnd_supply
// Fresh-randomness source for the DOM shared GF(2^2) multiplier. A seeded
// 64-bit Fibonacci LFSR produces one word per cycle. The low ZW bits of the
// word feed the multiplier's Z port and the upper 2*BN bits feed its B port.
// A load/warm-up FSM prepares the LFSR after every seed. A valid/ready
// handshake lets the S-box pipeline stall without losing or reusing bits.
module dom_rnd_supply #(
    parameter int SHARES                   = 2,
    parameter int FIRST_ORDER_OPTIMIZATION = 1,
    parameter int WARMUP_CYCLES            = 128,
    parameter int RESEED_INTERVAL          = 65535,
    localparam int BN    = ((FIRST_ORDER_OPTIMIZATION == 1) && (SHARES == 2)) ? 1 : SHARES,
    localparam int ZW    = SHARES * (SHARES - 1),
    localparam int RND_W = ZW + 2 * BN
) (
    input  logic              ClkxCI,
    input  logic              RstxRI,
    input  logic [63:0]       SeedxDI,
    input  logic              SeedValidxSI,
    input  logic              RndReadyxSI,
    output logic              RndValidxSO,
    output logic [ZW-1:0]     ZxDO,
    output logic [2*BN-1:0]   BxDO,
    output logic              ReseedReqxSO,
    output logic              BusyxSO
);

    // Parameter sanity: the multiplier needs two shares or more, and one word
    // must fit in the 64-bit LFSR.
    if (SHARES < 2) begin : g_chk_shares
        $error("dom_rnd_supply: SHARES must be at least 2");
    end
    if (RND_W > 64) begin : g_chk_width
        $error("dom_rnd_supply: SHARES*(SHARES-1)+2*BN must not exceed 64");
    end
    if (WARMUP_CYCLES < 0) begin : g_chk_warmup
        $error("dom_rnd_supply: WARMUP_CYCLES must not be negative");
    end
    if (RESEED_INTERVAL < 0) begin : g_chk_reseed
        $error("dom_rnd_supply: RESEED_INTERVAL must not be negative");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_WARMUP = 3'd2,
        ST_FILL   = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    localparam logic [31:0] WARMUP_LOAD  = 32'(WARMUP_CYCLES);
    localparam logic [31:0] RESEED_LIMIT = 32'(RESEED_INTERVAL);
    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

    state_t            state;
    state_t            state_nxt;

    logic [63:0]       lfsr;
    logic [RND_W-1:0]  word;
    logic              valid;
    logic              reseed_req;
    logic              busy;
    logic [31:0]       word_cnt;
    logic [31:0]       word_cnt_inc;
    logic [31:0]       warm_cnt;

    logic              seed_load;
    logic              adv_warm;
    logic              adv_fill;
    logic              adv_run;

    logic [63:0]       lfsr_adv;
    logic [RND_W-1:0]  word_adv;
    logic [63:0]       seed_fixed;

    // One word advance: RND_W Fibonacci steps of x^64+x^63+x^61+x^60+1,
    // unrolled. Bit k of the word is the feedback bit of step k.
    // Returns {word, lfsr_after}.
    function automatic logic [RND_W+63:0] word_advance(input logic [63:0] l_in);
        logic [63:0]      l;
        logic [RND_W-1:0] w;
        logic             f;
        l = l_in;
        w = '0;
        for (int k = 0; k < RND_W; k++) begin
            f    = l[63] ^ l[62] ^ l[60] ^ l[59];
            w[k] = f;
            l    = {l[62:0], f};
        end
        return {w, l};
    endfunction

    assign {word_adv, lfsr_adv} = word_advance(lfsr);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign seed_fixed   = (SeedxDI == 64'd0) ? 64'd1 : SeedxDI;
    assign word_cnt_inc = word_cnt + 32'd1;

    // State register.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A seed pulse overrides every state.
    always_comb begin
        state_nxt = state;
        if (SeedValidxSI) begin
            state_nxt = ST_SEED;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_SEED: begin
                    if (WARMUP_CYCLES > 0) begin
                        state_nxt = ST_WARMUP;
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end
                ST_WARMUP: begin
                    if (warm_cnt <= 32'd1) begin
                        state_nxt = ST_FILL;
                    end else begin
                        state_nxt = ST_WARMUP;
                    end
                end
                ST_FILL: begin
                    state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath control decode. With a seed pulse nothing advances, so a word
    // held under a simultaneous ready is discarded and never counted.
    always_comb begin
        seed_load = SeedValidxSI;
        adv_warm  = 1'b0;
        adv_fill  = 1'b0;
        adv_run   = 1'b0;
        if (!SeedValidxSI) begin
            case (state)
                ST_WARMUP: adv_warm = 1'b1;
                ST_FILL:   adv_fill = 1'b1;
                ST_RUN:    adv_run  = valid & RndReadyxSI;
                default: begin
                    adv_warm = 1'b0;
                    adv_fill = 1'b0;
                    adv_run  = 1'b0;
                end
            endcase
        end else begin
            adv_warm = 1'b0;
            adv_fill = 1'b0;
            adv_run  = 1'b0;
        end
    end

    // LFSR, output word and valid flag.
    // The seed is taken on the pulse edge, so the SEED cycle already holds
    // the loaded LFSR and the cleared valid flag.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            lfsr  <= 64'd0;
            word  <= '0;
            valid <= 1'b0;
        end else if (seed_load) begin
            lfsr  <= seed_fixed;
            valid <= 1'b0;
        end else if (adv_warm) begin
            lfsr  <= lfsr_adv;
        end else if (adv_fill || adv_run) begin
            lfsr  <= lfsr_adv;
            word  <= word_adv;
            valid <= 1'b1;
        end
    end

    // Warm-up down-counter, reloaded on every seed.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            warm_cnt <= 32'd0;
        end else if (seed_load) begin
            warm_cnt <= WARMUP_LOAD;
        end else if (adv_warm) begin
            warm_cnt <= warm_cnt - 32'd1;
        end
    end

    // Delivered-word counter (saturating) and sticky reseed request.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            word_cnt   <= 32'd0;
            reseed_req <= 1'b0;
        end else if (seed_load) begin
            word_cnt   <= 32'd0;
            reseed_req <= 1'b0;
        end else if (adv_run) begin
            if (word_cnt != CNT_MAX) begin
                word_cnt <= word_cnt_inc;
            end
            if ((RESEED_INTERVAL > 0) && (word_cnt != CNT_MAX) && (word_cnt_inc == RESEED_LIMIT)) begin
                reseed_req <= 1'b1;
            end
        end
    end

    // Busy flag, registered from the state being entered.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_SEED) || (state_nxt == ST_WARMUP);
        end
    end

    assign RndValidxSO  = valid;
    assign ZxDO         = word[ZW-1:0];
    assign BxDO         = word[RND_W-1:ZW];
    assign ReseedReqxSO = reseed_req;
    assign BusyxSO      = busy;

endmodule

// File: tb/tb_dom_rnd_supply.sv
// tb_dom_rnd_supply
// Two instances share one clock.
// Instance A: SHARES=2, FOO=1, no warm-up, RESEED_INTERVAL=4 (4-bit words).
// Instance B: SHARES=3, 128 warm-up cycles, default reseed interval (12-bit words).
// A bit-serial LFSR model predicts valid/busy/reseed and every presented
// word, and it is checked every cycle. Directed literals pin the model.
module tb_dom_rnd_supply;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, sv_a, rdy_a, val_a, req_a, busy_a;
    logic [63:0] seed_a;
    logic [1:0]  z_a, b_a;
    logic        rst_b, sv_b, rdy_b, val_b, req_b, busy_b;
    logic [63:0] seed_b;
    logic [5:0]  z_b, b_b;
    logic [63:0] word_a, word_b;

    assign word_a = {60'd0, b_a, z_a};
    assign word_b = {52'd0, b_b, z_b};

    dom_rnd_supply #(
        .SHARES(2), .FIRST_ORDER_OPTIMIZATION(1), .WARMUP_CYCLES(0), .RESEED_INTERVAL(4)
    ) dut_a (
        .ClkxCI(clk), .RstxRI(rst_a), .SeedxDI(seed_a), .SeedValidxSI(sv_a),
        .RndReadyxSI(rdy_a), .RndValidxSO(val_a), .ZxDO(z_a), .BxDO(b_a),
        .ReseedReqxSO(req_a), .BusyxSO(busy_a)
    );

    dom_rnd_supply #(
        .SHARES(3), .FIRST_ORDER_OPTIMIZATION(1), .WARMUP_CYCLES(128), .RESEED_INTERVAL(65535)
    ) dut_b (
        .ClkxCI(clk), .RstxRI(rst_b), .SeedxDI(seed_b), .SeedValidxSI(sv_b),
        .RndReadyxSI(rdy_b), .RndValidxSO(val_b), .ZxDO(z_b), .BxDO(b_b),
        .ReseedReqxSO(req_b), .BusyxSO(busy_b)
    );

    // model configuration, index 0 = A, 1 = B
    int c_rndw[2]   = '{4, 12};
    int c_warm[2]   = '{0, 128};
    int c_reseed[2] = '{4, 65535};

    // model state: values the outputs must show after the most recent edge
    logic [63:0] m_lfsr[2];
    logic [63:0] m_word[2];
    logic        m_valid[2];
    logic        m_busy[2];
    logic        m_req[2];
    int          m_phase[2];   // 0 idle, 1 busy, 2 about to present first word, 3 presenting
    int          m_lat[2];
    int          m_cnt[2];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          acc[2];
    int          busy_cnt_b;
    logic [63:0] hist_a[64];
    logic [63:0] ref_a[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // n serial LFSR steps; the output bits are packed LSB first
    task automatic model_bits(input int i, input int n, output logic [63:0] w);
        logic f;
        w = 64'd0;
        for (int k = 0; k < n; k++) begin
            f = m_lfsr[i][63] ^ m_lfsr[i][62] ^ m_lfsr[i][60] ^ m_lfsr[i][59];
            m_lfsr[i] = {m_lfsr[i][62:0], f};
            if (k < 64) w[k] = f;
        end
    endtask

    // advance the model over one clock edge given the inputs sampled at it
    task automatic model_edge(input int i, input logic rst, input logic sv,
                              input logic rdy, input logic [63:0] seed);
        logic [63:0] junk;
        if (rst) begin
            m_lfsr[i] = 64'd0; m_word[i] = 64'd0; m_valid[i] = 1'b0;
            m_busy[i] = 1'b0; m_req[i] = 1'b0; m_phase[i] = 0;
            m_lat[i] = 0; m_cnt[i] = 0;
        end else if (sv) begin
            m_lfsr[i] = (seed == 64'd0) ? 64'd1 : seed;
            for (int j = 0; j < c_warm[i]; j++) model_bits(i, c_rndw[i], junk);
            m_valid[i] = 1'b0; m_busy[i] = 1'b1; m_req[i] = 1'b0;
            m_cnt[i] = 0; m_phase[i] = 1; m_lat[i] = c_warm[i];
        end else begin
            case (m_phase[i])
                1: begin
                    if (m_lat[i] == 0) begin m_phase[i] = 2; m_busy[i] = 1'b0; end
                    else m_lat[i]--;
                end
                2: begin
                    model_bits(i, c_rndw[i], m_word[i]);
                    m_valid[i] = 1'b1; m_phase[i] = 3;
                end
                3: begin
                    if (rdy) begin
                        model_bits(i, c_rndw[i], m_word[i]);
                        m_cnt[i]++;
                        if (c_reseed[i] > 0 && m_cnt[i] == c_reseed[i]) m_req[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One cycle: compare at the falling edge, record acceptances, then step
    // the model with the inputs the next rising edge samples.
    task automatic tick();
        @(negedge clk);
        chk("a_valid", 64'(val_a), 64'(m_valid[0]));
        chk("a_busy",  64'(busy_a), 64'(m_busy[0]));
        chk("a_reseed_req", 64'(req_a), 64'(m_req[0]));
        if (m_valid[0]) chk("a_word", word_a, m_word[0]);
        chk("b_valid", 64'(val_b), 64'(m_valid[1]));
        chk("b_busy",  64'(busy_b), 64'(m_busy[1]));
        chk("b_reseed_req", 64'(req_b), 64'(m_req[1]));
        if (m_valid[1]) chk("b_word", word_b, m_word[1]);
        if (busy_b) busy_cnt_b++;
        if (val_a && rdy_a && !sv_a && !rst_a) begin
            if (acc[0] < 64) hist_a[acc[0]] = word_a;
            acc[0]++;
        end
        if (val_b && rdy_b && !sv_b && !rst_b) acc[1]++;
        model_edge(0, rst_a, sv_a, rdy_a, seed_a);
        model_edge(1, rst_b, sv_b, rdy_b, seed_b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int lat;
        acc[0] = 0; acc[1] = 0; busy_cnt_b = 0;
        rst_a = 1'b1; sv_a = 1'b0; rdy_a = 1'b0; seed_a = 64'd0;
        rst_b = 1'b1; sv_b = 1'b0; rdy_b = 1'b0; seed_b = 64'd0;
        model_edge(0, 1'b1, 1'b0, 1'b0, 64'd0);
        model_edge(1, 1'b1, 1'b0, 1'b0, 64'd0);
        @(posedge clk);
        #1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // reset state
        chk("rst_a_valid", 64'(val_a), 64'd0);
        chk("rst_a_z", 64'(z_a), 64'd0);
        chk("rst_a_b", 64'(b_a), 64'd0);
        chk("rst_a_req", 64'(req_a), 64'd0);
        chk("rst_a_busy", 64'(busy_a), 64'd0);
        chk("rst_b_word", word_b, 64'd0);

        // no seed: stays idle despite ready
        rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (10) tick();
        chk("idle_a_valid", 64'(val_a), 64'd0);
        chk("idle_b_valid", 64'(val_b), 64'd0);

        // A: seed 1, no warm-up, continuous ready
        acc[0] = 0;
        seed_a = 64'h1; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        lat = 0;
        while (!val_a && lat < 10) begin tick(); lat++; end
        chk("a_fill_latency", 64'(lat), 64'd2);
        chk("a_first_z", 64'(z_a), 64'd0);
        chk("a_first_b", 64'(b_a), 64'd0);
        n = 0;
        while (acc[0] < 1000 && n < 2000) begin tick(); n++; end
        chk("a_accept_count", 64'(acc[0]), 64'd1000);
        chk("a_seed1_word0", hist_a[0], 64'h0);
        chk("a_seed1_word14", hist_a[14], 64'h8);
        chk("a_seed1_word15", hist_a[15], 64'hD);
        for (int k = 0; k < 64; k++) ref_a[k] = hist_a[k];

        // A: seed 0 must repeat the seed 1 sequence (pulse lands in RUN with ready)
        acc[0] = 0;
        seed_a = 64'h0; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        n = 0;
        while (acc[0] < 64 && n < 200) begin tick(); n++; end
        chk("a_seed0_count", 64'(acc[0]), 64'd64);
        for (int k = 0; k < 64; k++) chk("a_seed0_vs_seed1", hist_a[k], ref_a[k]);

        // A: reseed request after the 4th accepted word, cleared by a new seed
        acc[0] = 0;
        seed_a = 64'h0123_4567_89AB_CDEF; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        chk("a_req_clear_in_seed", 64'(req_a), 64'd0);
        chk("a_busy_in_seed", 64'(busy_a), 64'd1);
        n = 0;
        while (acc[0] < 3 && n < 20) begin tick(); n++; end
        chk("a_req_after_3", 64'(req_a), 64'd0);
        while (acc[0] < 4 && n < 20) begin tick(); n++; end
        chk("a_req_after_4", 64'(req_a), 64'd1);
        repeat (5) tick();
        chk("a_req_sticky", 64'(req_a), 64'd1);

        // A: seed pulse in RUN with ready high drops valid and restarts the sequence
        acc[0] = 0;
        seed_a = 64'h1; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        chk("a_valid_drop", 64'(val_a), 64'd0);
        chk("a_req_drop", 64'(req_a), 64'd0);
        n = 0;
        while (acc[0] < 16 && n < 40) begin tick(); n++; end
        chk("a_restart_count", 64'(acc[0]), 64'd16);
        chk("a_restart_word0", hist_a[0], 64'h0);
        chk("a_restart_word14", hist_a[14], 64'h8);
        chk("a_restart_word15", hist_a[15], 64'hD);

        // B: warm-up, random backpressure, 10k words
        rdy_a = 1'b0;
        acc[1] = 0; busy_cnt_b = 0;
        seed_b = 64'hDEAD_BEEF_0123_4567; sv_b = 1'b1;
        tick();
        sv_b = 1'b0;
        n = 0;
        while (acc[1] < 10000 && n < 40000) begin
            rdy_b = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        chk("b_accept_count", 64'(acc[1]), 64'd10000);
        chk("b_busy_cycles", 64'(busy_cnt_b), 64'd129);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
